// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan request, 4:1 mux select/return and frame handshake bundle
//   start, mode        scan request / single(0) or continuous(1) selection
//   sel, q_in          channel select to the downstream mux and its returned output
//   frame, frame_valid assembled 4-bit frame and its valid flag
//   frame_ready        consumer accept
//   busy, overrun      scanning status and sticky overwrite flag
// master: the scan controller; slave: the requester/consumer and mux side.
interface mux_scan_ctrl_if;
    logic       start;
    logic       mode;
    logic [1:0] sel;
    logic       q_in;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic       overrun;
    modport master (
        input  start, mode, q_in, frame_ready,
        output sel, frame, frame_valid, busy, overrun
    );
    modport slave (
        output start, mode, q_in, frame_ready,
        input  sel, frame, frame_valid, busy, overrun
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through its channels and assembles q_in samples into frames
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mux_scan_ctrl_if.master (start/mode in, sel/q_in mux loop, frame handshake, busy/overrun)
//   DWELL    cycles spent on each channel before sampling, 1..15
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mux_scan_ctrl_if.master       bus
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [3:0] LAST = 4'(DWELL - 1);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sh_q, sh_d;
    logic [1:0] sel_q, sel_d;
    logic       cont_q, cont_d;
    logic       stop_q, stop_d;
    logic [3:0] frame_q, frame_d;
    logic       fv_q, fv_d;
    logic       ovr_q, ovr_d;
    logic       samp, done;
    assign samp = (state_q == SCAN) && (cnt_q == LAST);
    assign done = samp && (sel_q == 2'd3);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sel_d   = sel_q;
        cont_d  = cont_q;
        stop_d  = stop_q;
        frame_d = frame_q;
        fv_d    = fv_q;
        ovr_d   = ovr_q;
        if (fv_q && bus.frame_ready)
            fv_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = SCAN;
                cnt_d   = 4'd0;
                sel_d   = 2'd0;
                cont_d  = bus.mode;
                stop_d  = 1'b0;
                ovr_d   = 1'b0;
            end
        end else begin
            cnt_d = samp ? 4'd0 : cnt_q + 4'd1;
            if (bus.start && cont_q)
                stop_d = 1'b1;
            // Samples shift in from the top, so channel 0 ends up in sh_q[0].
            if (samp) begin
                sh_d  = {bus.q_in, sh_q[2:1]};
                sel_d = sel_q + 2'd1;
            end
            // A completing frame wins over a same-edge accept: valid stays set.
            if (done) begin
                frame_d = {bus.q_in, sh_q};
                fv_d    = 1'b1;
                if (fv_q && !bus.frame_ready)
                    ovr_d = 1'b1;
                if (!cont_q || stop_q) begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                    stop_d  = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 3'd0;
            sel_q   <= 2'd0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            frame_q <= 4'd0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sel_q   <= sel_d;
            cont_q  <= cont_d;
            stop_q  <= stop_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.sel         = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;
    assign bus.busy        = (state_q == SCAN);
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl with DWELL=4 and DWELL=1 instances
module tb_mux_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] ch_a = 4'h0;
    logic [3:0] ch_b = 4'h0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic       fv_pa = 1'b0, fv_pb = 1'b0;
    logic [3:0] fr_pa = 4'h0, fr_pb = 4'h0;

    mux_scan_ctrl_if a ();
    mux_scan_ctrl_if b ();

    mux_scan_ctrl #(.DWELL(4)) u_a (.clk(clk), .reset_n(reset_n), .bus(a));
    mux_scan_ctrl #(.DWELL(1)) u_b (.clk(clk), .reset_n(reset_n), .bus(b));

    assign a.q_in = ch_a[a.sel];
    assign b.q_in = ch_b[b.sel];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic m);
        a.mode  = m;
        a.start = 1'b1;
        tick(1);
        a.start = 1'b0;
    endtask

    // A new frame is visible when valid rises or the held frame is overwritten.
    always @(negedge clk) begin
        if (a.frame_valid && (!fv_pa || a.frame != fr_pa)) begin
            chk("a_expected_pending", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) chk("a_frame", a.frame, qa.pop_front());
        end
        if (b.frame_valid && (!fv_pb || b.frame != fr_pb)) begin
            chk("b_expected_pending", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) chk("b_frame", b.frame, qb.pop_front());
        end
        fv_pa = a.frame_valid;
        fr_pa = a.frame;
        fv_pb = b.frame_valid;
        fr_pb = b.frame;
    end

    initial begin
        a.start = 1'b0; a.mode = 1'b0; a.frame_ready = 1'b0;
        b.start = 1'b0; b.mode = 1'b0; b.frame_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_sel", a.sel, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_fv", a.frame_valid, 0);
        chk("rst_frame", a.frame, 0);
        chk("rst_ovr", a.overrun, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // single scan, consumer holding off
        ch_a = 4'h5;
        qa.push_back(4'h5);
        pulse_a(1'b0);
        chk("single_sel_e0", a.sel, 0);
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            chk("single_sel", a.sel, (e < 16) ? e / 4 : 0);
            chk("single_busy", a.busy, (e < 16) ? 1 : 0);
        end
        chk("single_fv", a.frame_valid, 1);
        tick(2);
        chk("single_fv_hold", a.frame_valid, 1);
        a.frame_ready = 1'b1;
        tick(1);
        chk("single_acc_fv", a.frame_valid, 0);
        chk("single_acc_frame", a.frame, 4'h5);

        // continuous, consumer always ready, stop requested mid-frame
        ch_a = 4'h5;
        qa.push_back(4'h5); qa.push_back(4'hA); qa.push_back(4'hA);
        pulse_a(1'b1);
        tick(16);
        chk("cont_fv16", a.frame_valid, 1);
        ch_a = 4'hA;
        tick(1);
        chk("cont_fv17", a.frame_valid, 0);
        tick(15);
        chk("cont_fv32", a.frame_valid, 1);
        chk("cont_ovr", a.overrun, 0);
        tick(11);
        pulse_a(1'b1);
        tick(1);
        pulse_a(1'b1);
        tick(1);
        chk("stop_busy47", a.busy, 1);
        tick(1);
        chk("stop_busy48", a.busy, 0);
        chk("stop_sel48", a.sel, 0);
        tick(2);

        // overrun: nothing accepted across two completions
        a.frame_ready = 1'b0;
        ch_a = 4'h3;
        qa.push_back(4'h3); qa.push_back(4'hC); qa.push_back(4'h6);
        pulse_a(1'b1);
        tick(16);
        ch_a = 4'hC;
        tick(16);
        chk("ovr_flag", a.overrun, 1);
        chk("ovr_fv", a.frame_valid, 1);
        chk("ovr_frame", a.frame, 4'hC);
        ch_a = 4'h6;
        pulse_a(1'b1);
        tick(15);
        chk("ovr_idle", a.busy, 0);
        chk("ovr_sticky", a.overrun, 1);
        a.frame_ready = 1'b1;
        tick(1);
        chk("ovr_acc_fv", a.frame_valid, 0);
        chk("ovr_acc_frame", a.frame, 4'h6);
        qa.push_back(4'h6);
        pulse_a(1'b0);
        chk("ovr_cleared", a.overrun, 0);
        tick(18);

        // accept lands on the same edge as the next completion
        a.frame_ready = 1'b0;
        ch_a = 4'h9;
        qa.push_back(4'h9); qa.push_back(4'h2); qa.push_back(4'h7);
        pulse_a(1'b1);
        tick(16);
        ch_a = 4'h2;
        tick(15);
        a.frame_ready = 1'b1;
        tick(1);
        a.frame_ready = 1'b0;
        chk("sim_fv", a.frame_valid, 1);
        chk("sim_frame", a.frame, 4'h2);
        chk("sim_ovr", a.overrun, 0);
        ch_a = 4'h7;
        pulse_a(1'b1);
        tick(15);
        chk("sim_ovr48", a.overrun, 1);
        chk("sim_busy48", a.busy, 0);
        a.frame_ready = 1'b1;
        tick(2);

        // reset between edges while sel = 10 discards the partial frame
        ch_a = 4'hF;
        pulse_a(1'b0);
        tick(8);
        chk("mid_sel", a.sel, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_sel", a.sel, 0);
        chk("mid_rst_busy", a.busy, 0);
        chk("mid_rst_fv", a.frame_valid, 0);
        chk("mid_rst_frame", a.frame, 0);
        chk("mid_rst_ovr", a.overrun, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        qa.push_back(4'hF);
        pulse_a(1'b0);
        chk("fresh_sel", a.sel, 0);
        chk("fresh_busy", a.busy, 1);
        tick(4);
        chk("fresh_sel4", a.sel, 1);
        tick(14);

        // DWELL = 1: sample and step every cycle
        ch_b = 4'hB;
        qb.push_back(4'hB);
        b.mode = 1'b0;
        b.start = 1'b1;
        tick(1);
        b.start = 1'b0;
        chk("d1_sel0", b.sel, 0);
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            chk("d1_sel", b.sel, e);
            chk("d1_fv_low", b.frame_valid, 0);
        end
        tick(1);
        chk("d1_fv4", b.frame_valid, 1);
        chk("d1_busy4", b.busy, 0);
        tick(3);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4, clock cycles spent on each mux channel before sampling; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle request: in IDLE begins a scan; in continuous SCAN requests stop.
REQ-005 mode  input  1  0 = single frame, 1 = continuous; sampled only when start is accepted in IDLE.
REQ-006 sel  output  2  channel select driven to the downstream 4:1 mux.
REQ-007 q_in  input  1  selected mux output (Q) returned from the 4:1 mux.
REQ-008 frame  output  4  assembled frame; frame[i] = q_in sampled while sel == i.
REQ-009 frame_valid  output  1  frame holds an unaccepted result.
REQ-010 frame_ready  input  1  consumer accepts frame when frame_valid and frame_ready are both high at a rising edge.
REQ-011 busy  output  1  high while in SCAN.
REQ-012 overrun  output  1  sticky flag: a completed frame overwrote an unaccepted one.

Function
REQ-013 States SHALL be IDLE and SCAN; a 4-bit dwell counter cnt and a 3-bit shift/assembly register SHALL support SCAN.
REQ-014 IDLE: sel = 00, busy = 0; start = 1 -> SCAN with sel = 00, cnt = 0, latched mode, overrun cleared.
REQ-015 SCAN: cnt increments each cycle; at the edge where cnt == DWELL-1, q_in is captured into bit sel, cnt returns to 0, and sel advances by 1.
REQ-016 Frame completion: at the sample edge with sel == 11, frame loads all four bits, including that cycle's q_in, and frame_valid sets on the same edge.
REQ-017 Latency: with start accepted at edge 0, frame_valid rises at edge 4*DWELL; sel changes at edges DWELL, 2*DWELL and 3*DWELL.
REQ-018 Single mode: at completion, state -> IDLE, sel -> 00, busy -> 0 on the same edge.
REQ-019 Continuous mode: at completion, sel wraps 11 -> 00 and scanning continues with no idle cycle; the frame period is exactly 4*DWELL cycles.
REQ-020 Stop: start = 1 during continuous SCAN sets a stop-pending flag; the current frame completes normally and the block then enters IDLE as in single mode; extra start pulses are ignored.
REQ-021 start = 1 during single-mode SCAN SHALL be ignored.
REQ-022 Handshake: frame_valid clears on an accept edge unless a new frame completes on that same edge, in which case frame_valid stays 1, frame takes the new value and overrun is unchanged.
REQ-023 Overrun: completion while frame_valid = 1 and frame_ready = 0 sets overrun, overwrites frame with the newest value and keeps frame_valid = 1.
REQ-024 frame, frame_valid and overrun SHALL NOT change except at completion, accept, or reset; an accepted frame retains its last value with frame_valid = 0.
REQ-025 DWELL = 1 SHALL sample every cycle, with sel advancing on every edge during SCAN.

Reset
REQ-026 reset_n = 0 SHALL immediately, without waiting for clk, force: IDLE, sel = 00, cnt = 0, frame = 0000, frame_valid = 0, overrun = 0, busy = 0, stop-pending = 0.
REQ-027 Reset asserted mid-scan SHALL discard the partial frame; the first start after release begins a fresh scan at sel = 00.

Verification
REQ-028 Reset mid-scan: assert reset_n = 0 between clock edges while sel = 10 -> all outputs are at reset values before the next edge.
REQ-029 Single scan: DWELL = 4, mux model with channel = 4'h5, mode = 0, start pulse at edge 0 -> sel is 00/01/10/11 for 4 cycles each; frame = 4'h5 and frame_valid = 1 at edge 16; busy = 0 at edge 16.
REQ-030 Continuous scan: frame_ready = 1; channel changes 4'h5 -> 4'hA between frames -> frame_valid pulses for one cycle at edges 16 and 32 with frames 5 then A; no overrun.
REQ-031 Overrun: continuous mode, frame_ready = 0 -> at edge 32 overrun = 1, frame = latest value, frame_valid = 1; the next start in IDLE clears overrun.
REQ-032 Simultaneous accept and completion: frame_ready = 1 exactly at edge 32 while frame 1 is still pending -> frame_valid remains 1, frame = frame 2, overrun = 0.
REQ-033 Stop and DWELL = 1: start pulse at edge 6 of a continuous scan -> scanning ends at edge 8 with busy = 0; with DWELL = 1, sel steps every cycle and frame_valid rises at edge 4.
